clock_freq_monitor: RTL and testbench

// - Receiving end of clock_divider: measures an incoming divided clock (clk_in) against sys_clk.
// - Reports period in sys_clk cycles, pass/fail against the expected frequency, and loss-of-clock timeout.
// - Sits beside the divider output (or any slow board clock) as a built-in self-check / health monitor.

---
 rtl/clock_freq_monitor_if.sv | 13 +
 rtl/clock_freq_monitor.sv | 103 ++++++++++
 tb/tb_clock_freq_monitor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/clock_freq_monitor_if.sv
// clock_freq_monitor_if: clock-under-test, measurement handshake and result bus of clock_freq_monitor.
interface clock_freq_monitor_if #(parameter int CNT_W = 27);
    logic             clk_in;
    logic             start;
    logic             busy;
    logic             meas_valid;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             freq_ok;
    logic             timeout;
    modport master (output clk_in, start, input busy, meas_valid, period_cnt, high_cnt, freq_ok, timeout);
    modport slave  (input clk_in, start, output busy, meas_valid, period_cnt, high_cnt, freq_ok, timeout);
endinterface

// File: rtl/clock_freq_monitor.sv
// clock_freq_monitor: measures the clk_in period in sys_clk cycles, checks it against the expected
// frequency and flags loss of clock; define CLK_MON_DUTY_EN to also measure the clk_in high time.
module clock_freq_monitor #(
    parameter int INPUT_CLOCK_FREQUENCY  = 50_000_000,
    parameter int OUTPUT_CLOCK_FREQUENCY = 1,
    parameter int TOL_CYCLES             = 1
) (
    input logic sys_clk,
    input logic rstn,
    clock_freq_monitor_if.slave mon
);
    localparam int EXP_PERIOD     = INPUT_CLOCK_FREQUENCY / OUTPUT_CLOCK_FREQUENCY;
    localparam int TIMEOUT_CYCLES = 2 * EXP_PERIOD;
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] OK_LO   = CNT_W'(EXP_PERIOD - TOL_CYCLES);
    localparam logic [CNT_W-1:0] OK_HI   = CNT_W'(EXP_PERIOD + TOL_CYCLES);
    // Firing one count early makes the pulse land on the cycle cnt reaches TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t           state_q;
    logic             sync1_q, sync2_q, sync3_q;
    logic [CNT_W-1:0] cnt_q, period_q;
    logic             busy_q, valid_q, ok_q, to_q;
    logic             rise;

    assign rise = sync2_q & ~sync3_q;

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, high_q;
    assign mon.high_cnt = high_q;
`else
    assign mon.high_cnt = '0;
`endif

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            {sync3_q, sync2_q, sync1_q} <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            to_q     <= 1'b0;
`ifdef CLK_MON_DUTY_EN
            hcnt_q   <= '0;
            high_q   <= '0;
`endif
        end else begin
            {sync3_q, sync2_q, sync1_q} <= {sync2_q, sync1_q, mon.clk_in};
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (mon.start) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM, MEASURE: begin
                    cnt_q <= cnt_q + 1'b1;
`ifdef CLK_MON_DUTY_EN
                    hcnt_q <= hcnt_q + CNT_W'(sync2_q);
`endif
                    if (rise && state_q == ARM) begin
                        cnt_q   <= CNT_W'(1);
`ifdef CLK_MON_DUTY_EN
                        hcnt_q  <= CNT_W'(1);
`endif
                        state_q <= MEASURE;
                    end else if (rise) begin
                        period_q <= cnt_q;
`ifdef CLK_MON_DUTY_EN
                        high_q   <= hcnt_q;
`endif
                        ok_q     <= (cnt_q >= OK_LO) && (cnt_q <= OK_HI);
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        to_q    <= 1'b1;
                        ok_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mon.busy       = busy_q;
    assign mon.meas_valid = valid_q;
    assign mon.period_cnt = period_q;
    assign mon.freq_ok    = ok_q;
    assign mon.timeout    = to_q;
endmodule

// File: tb/tb_clock_freq_monitor.sv
// tb_clock_freq_monitor: table-driven, randomized and hand-written checks of clock_freq_monitor
// with EXP_PERIOD=10, TOL_CYCLES=1, TIMEOUT=20.
module tb_clock_freq_monitor;
    localparam int EXP = 10, TOL = 1, TMO = 20, W = 5;

    typedef struct {
        int hi; int lo; bit stk;
        int period; int high; bit ok; bit to;
    } vec_t;

    logic sys_clk = 1'b0;
    logic rstn = 1'b0;
    int   hi_len = 5, lo_len = 5, ph = 0;
    bit   stuck = 1'b1;
    int   n_chk = 0, n_fail = 0;
    int   last_period = 0, last_high = 0;

    clock_freq_monitor_if #(.CNT_W(W)) bus();

    clock_freq_monitor #(
        .INPUT_CLOCK_FREQUENCY(100),
        .OUTPUT_CLOCK_FREQUENCY(10),
        .TOL_CYCLES(TOL)
    ) dut (
        .sys_clk(sys_clk),
        .rstn(rstn),
        .mon(bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    // clk_in: hi_len cycles high then lo_len cycles low, or held low while stuck
    always @(negedge sys_clk) begin
        if (stuck) begin
            bus.clk_in = 1'b0;
            ph = 0;
        end else begin
            bus.clk_in = (ph < hi_len);
            ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a clock of period P either yields P (within timeout) or a loss-of-clock event.
    function automatic vec_t model(input int hi, input int lo, input bit stk);
        vec_t v;
        v.hi = hi; v.lo = lo; v.stk = stk;
        v.to = stk || (hi + lo >= TMO);
        v.period = hi + lo;
        v.high = hi;
        v.ok = !v.to && (v.period >= EXP - TOL) && (v.period <= EXP + TOL);
        return v;
    endfunction

    function automatic int duty(input int h);
`ifdef CLK_MON_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic pulse_start();
        @(negedge sys_clk) bus.start = 1'b1;
        @(negedge sys_clk) bus.start = 1'b0;
    endtask

    task automatic run(input vec_t v, input string tag);
        bit got_v = 0, got_t = 0;
        int extra = 0;
        hi_len = v.hi; lo_len = v.lo; stuck = v.stk;
        repeat (25) @(negedge sys_clk);
        pulse_start();
        for (int i = 0; i < 80 && !got_v && !got_t; i++) begin
            @(posedge sys_clk); #1;
            got_v = bus.meas_valid;
            got_t = bus.timeout;
        end
        if (!v.to) begin
            last_period = v.period;
            last_high = duty(v.high);
        end
        chk({tag, " valid"}, 32'(got_v), 32'(!v.to));
        chk({tag, " timeout"}, 32'(got_t), 32'(v.to));
        chk({tag, " period"}, 32'(bus.period_cnt), 32'(last_period));
        chk({tag, " high"}, 32'(bus.high_cnt), 32'(last_high));
        chk({tag, " freq_ok"}, 32'(bus.freq_ok), 32'(v.ok));
        chk({tag, " busy"}, 32'(bus.busy), 32'(0));
        for (int i = 0; i < 25; i++) begin
            @(posedge sys_clk); #1;
            extra += int'(bus.meas_valid) + int'(bus.timeout);
        end
        chk({tag, " no extra pulse"}, 32'(extra), 32'(0));
    endtask

    initial begin
        vec_t tbl[8];
        vec_t v;
        int k, nv, p, h;
        tbl[0] = '{5, 5, 0, 10, 5, 1, 0};
        tbl[1] = '{6, 6, 0, 12, 6, 0, 0};
        tbl[2] = '{4, 5, 0, 9, 4, 1, 0};
        tbl[3] = '{3, 7, 0, 10, 3, 1, 0};
        tbl[4] = '{5, 6, 0, 11, 5, 1, 0};
        tbl[5] = '{4, 4, 0, 8, 4, 0, 0};
        tbl[6] = '{0, 0, 1, 0, 0, 0, 1};
        tbl[7] = '{10, 10, 0, 20, 10, 0, 1};
        bus.start = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("reset busy", 32'(bus.busy), 32'(0));
        chk("reset valid", 32'(bus.meas_valid), 32'(0));
        chk("reset period", 32'(bus.period_cnt), 32'(0));
        chk("reset high", 32'(bus.high_cnt), 32'(0));
        chk("reset freq_ok", 32'(bus.freq_ok), 32'(0));
        chk("reset timeout", 32'(bus.timeout), 32'(0));
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            p = $urandom_range(2, TMO - 1);
            h = $urandom_range(1, p - 1);
            run(model(h, p - h, $urandom_range(0, 7) == 0), $sformatf("rnd%0d", i));
        end

        // loss of clock: pulse exactly TMO cycles after ARM entry
        run(model(5, 5, 0), "pre-timeout");
        stuck = 1'b1;
        repeat (5) @(negedge sys_clk);
        bus.start = 1'b1;
        @(posedge sys_clk); #1;
        bus.start = 1'b0;
        chk("arm busy", 32'(bus.busy), 32'(1));
        k = 0; nv = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            @(posedge sys_clk); #1;
            nv += int'(bus.meas_valid);
            if (bus.timeout) k = i;
        end
        chk("timeout latency", 32'(k), 32'(TMO));
        chk("timeout no valid", 32'(nv), 32'(0));
        chk("timeout busy", 32'(bus.busy), 32'(0));
        chk("timeout freq_ok", 32'(bus.freq_ok), 32'(0));
        chk("timeout period held", 32'(bus.period_cnt), 32'(10));
        @(posedge sys_clk); #1;
        chk("timeout one cycle", 32'(bus.timeout), 32'(0));

        // start re-pulsed mid-measurement is ignored
        hi_len = 5; lo_len = 5; stuck = 1'b0;
        repeat (25) @(negedge sys_clk);
        pulse_start();
        repeat (8) @(negedge sys_clk);
        pulse_start();
        repeat (3) @(negedge sys_clk);
        pulse_start();
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge sys_clk); #1;
            nv += int'(bus.meas_valid);
        end
        chk("restart valid count", 32'(nv), 32'(1));
        chk("restart period", 32'(bus.period_cnt), 32'(10));
        chk("restart freq_ok", 32'(bus.freq_ok), 32'(1));

        // reset in the middle of a measurement
        hi_len = 6; lo_len = 6;
        repeat (25) @(negedge sys_clk);
        pulse_start();
        repeat (8) @(negedge sys_clk);
        rstn = 1'b0;
        #1;
        chk("midrst busy", 32'(bus.busy), 32'(0));
        chk("midrst period", 32'(bus.period_cnt), 32'(0));
        chk("midrst freq_ok", 32'(bus.freq_ok), 32'(0));
        nv = 0;
        repeat (2) begin
            @(posedge sys_clk); #1;
            nv += int'(bus.meas_valid) + int'(bus.timeout);
        end
        @(negedge sys_clk) rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge sys_clk); #1;
            nv += int'(bus.meas_valid) + int'(bus.timeout) + int'(bus.busy);
        end
        chk("midrst no pulses", 32'(nv), 32'(0));
        last_period = 0; last_high = 0;
        run(model(3, 7, 0), "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
